seq_divider: RTL and testbench

Sequential 8-bit radix-2 non-restoring divider: the inverse of the team's Booth multiplier, sharing its datapath flavour (one add/subtract per cycle, shift register pair A:Q). It accepts a dividend/divisor pair on a start pulse and returns quotient and remainder after a fixed number of cycles. It sits beside the multiplier in the arithmetic unit and uses the same start/busy/done handshake.

---
 rtl/div_pkg.sv | 13 +
 rtl/seq_divider_if.sv | 25 ++
 rtl/addsub_cla.sv | 52 +++++
 rtl/seq_divider.sv | 170 +++++++++++++++++
 tb/tb_seq_divider.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential non-restoring divider.
// Latency and handshake live in seq_divider; this package has no logic.
package div_pkg;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } state_t;
endpackage

// File: rtl/seq_divider_if.sv
// start/busy/done handshake bundle between a requester (master) and the divider (slave).
// No backpressure: start is only honoured while the divider is idle.
interface seq_divider_if;
  import div_pkg::*;

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/addsub_cla.sv
// W-bit combinational add/subtract (sub=1: a + ~b + 1) from 4-bit lookahead slices, rippled between slices.
// Zero latency, no flow control.
module addsub_cla #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);
  localparam int NS = (W + 3) / 4;

  logic [W-1:0]  bx;
  logic [NS-1:0] cs;

  assign bx    = b ^ {W{sub}};
  assign cs[0] = sub;

  for (genvar s = 0; s < NS; s++) begin : g_slice
    localparam int LO = 4 * s;
    localparam int N  = ((W - LO) < 4) ? (W - LO) : 4;
    // The top slice has no carry-out consumer, so it stops one carry short.
    localparam int NC = (s == NS - 1) ? (N - 1) : N;

    logic [NC:0] cc;

    always_comb begin
      logic cj;
      logic pp;
      cc[0] = cs[s];
      for (int j = 1; j <= NC; j++) begin
        cj = 1'b0;
        for (int k = 0; k < j; k++) begin
          pp = 1'b1;
          for (int m = k + 1; m < j; m++) pp = pp & (a[LO+m] ^ bx[LO+m]);
          cj = cj | (a[LO+k] & bx[LO+k] & pp);
        end
        pp = 1'b1;
        for (int m = 0; m < j; m++) pp = pp & (a[LO+m] ^ bx[LO+m]);
        cc[j] = cj | (pp & cs[s]);
      end
    end

    for (genvar j = 0; j < N; j++) begin : g_sum
      assign y[LO+j] = a[LO+j] ^ bx[LO+j] ^ cc[j];
    end

    if (s < NS - 1) begin : g_co
      assign cs[s+1] = cc[NC];
    end
  end
endmodule

// File: rtl/seq_divider.sv
// Radix-2 non-restoring divider, WIDTH+2 cycles start-to-done (1 cycle on divide-by-zero); DIV_SIGNED_EN selects two's complement.
// start is ignored while busy or in DONE; no queuing, results hold until the next accepted start.
module seq_divider
  import div_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  dif
);
  state_t           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
`ifdef DIV_SIGNED_EN
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             ovf_pend_q, ovf_pend_d;
`endif

  logic [WIDTH:0]   add_a, add_y;
  logic             add_sub;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, rem_mag;

  addsub_cla #(.W(WIDTH + 1)) u_addsub (
    .a   (add_a),
    .b   ({1'b0, m_q}),
    .sub (add_sub),
    .y   (add_y)
  );

`ifdef DIV_SIGNED_EN
  assign dvd_mag = dif.dividend[WIDTH-1] ? -dif.dividend : dif.dividend;
  assign dvs_mag = dif.divisor[WIDTH-1]  ? -dif.divisor  : dif.divisor;
`else
  assign dvd_mag = dif.dividend;
  assign dvs_mag = dif.divisor;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
`ifdef DIV_SIGNED_EN
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    ovf_pend_d = ovf_pend_q;
`endif
    add_a   = a_q;
    add_sub = 1'b0;
    rem_mag = a_q[WIDTH-1:0];

    case (state_q)
      IDLE: begin
        if (dif.start) begin
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          if (dif.divisor == '0) begin
            quo_d   = '1;
            rem_d   = dif.dividend;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            a_d     = '0;
            q_d     = dvd_mag;
            m_d     = dvs_mag;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = ITER;
`ifdef DIV_SIGNED_EN
            neg_quo_d  = dif.dividend[WIDTH-1] ^ dif.divisor[WIDTH-1];
            neg_rem_d  = dif.dividend[WIDTH-1];
            ovf_pend_d = (dif.dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                         (dif.divisor == '1);
`endif
          end
        end
      end
      ITER: begin
        // Shift {A,Q} left, then subtract M if A was non-negative, else add it back.
        add_a   = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
        add_sub = ~a_q[WIDTH];
        a_d     = add_y;
        q_d     = {q_q[WIDTH-2:0], ~add_y[WIDTH]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        rem_mag = a_q[WIDTH] ? add_y[WIDTH-1:0] : a_q[WIDTH-1:0];
`ifdef DIV_SIGNED_EN
        quo_d = neg_quo_q ? -q_q : q_q;
        rem_d = neg_rem_q ? -rem_mag : rem_mag;
        ovf_d = ovf_pend_q;
`else
        quo_d = q_q;
        rem_d = rem_mag;
`endif
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
`ifdef DIV_SIGNED_EN
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      ovf_pend_q <= ovf_pend_d;
`endif
    end
  end

  assign dif.busy        = busy_q;
  assign dif.done        = done_q;
  assign dif.quotient    = quo_q;
  assign dif.remainder   = rem_q;
  assign dif.div_by_zero = dbz_q;
  assign dif.overflow    = ovf_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider; expectations depend on whether DIV_SIGNED_EN is defined.
// A scoreboard queue is filled at issue time and drained by a monitor on every done pulse.
module tb_seq_divider;
  import div_pkg::*;

`ifdef DIV_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       ovf;
    int         t0;
    int         busy_n;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  int   busy_cnt;
  int   done_cnt;
  exp_t sb[$];

  seq_divider_if dif();

  seq_divider u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dif   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (dif.busy) busy_cnt++;
      if (dif.done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("quotient",    int'(dif.quotient),    int'(e.q));
          chk("remainder",   int'(dif.remainder),   int'(e.r));
          chk("div_by_zero", int'(dif.div_by_zero), int'(e.dbz));
          chk("overflow",    int'(dif.overflow),    int'(e.ovf));
          chk("latency",     cyc - e.t0,            e.dbz ? 0 : WIDTH + 1);
          chk("busy_cycles", busy_cnt,              e.busy_n);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((dif.busy || dif.done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("idle_timeout", 1, 0);
  endtask

  task automatic push_exp(input logic [7:0] q, input logic [7:0] r,
                          input logic dbz, input logic ovf);
    exp_t e;
    e.q      = q;
    e.r      = r;
    e.dbz    = dbz;
    e.ovf    = ovf;
    e.t0     = cyc + 1;
    e.busy_n = dbz ? 0 : WIDTH + 1;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [7:0] dvd, input logic [7:0] dvs,
                       input logic [7:0] q, input logic [7:0] r,
                       input logic dbz, input logic ovf);
    wait_idle();
    dif.dividend = dvd;
    dif.divisor  = dvs;
    push_exp(q, r, dbz, ovf);
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"},      int'(dif.busy),        0);
    chk({tag, "_done"},      int'(dif.done),        0);
    chk({tag, "_quotient"},  int'(dif.quotient),    0);
    chk({tag, "_remainder"}, int'(dif.remainder),   0);
    chk({tag, "_dbz"},       int'(dif.div_by_zero), 0);
    chk({tag, "_ovf"},       int'(dif.overflow),    0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int n;
    total    = 0;
    bad      = 0;
    busy_cnt = 0;
    done_cnt = 0;
    rst_n        = 1'b0;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    #1;
    chk_zero_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    issue(8'd100, 8'd7,  8'h0E, 8'h02, 1'b0, 1'b0);
    issue(8'h9C,  8'd7,  SGN ? 8'hF2 : 8'h16, SGN ? 8'hFE : 8'h02, 1'b0, 1'b0);
    issue(8'd100, 8'hF9, SGN ? 8'hF2 : 8'h00, SGN ? 8'h02 : 8'h64, 1'b0, 1'b0);
    issue(8'hFF,  8'h01, 8'hFF, 8'h00, 1'b0, 1'b0);
    issue(8'hFF,  8'hFF, 8'h01, 8'h00, 1'b0, 1'b0);
    issue(8'd55,  8'd0,  8'hFF, 8'd55, 1'b1, 1'b0);
    issue(8'h80,  8'hFF, SGN ? 8'h80 : 8'h00, SGN ? 8'h00 : 8'h80, 1'b0, SGN);

    // Abort an operation with reset four cycles after start.
    wait_idle();
    dif.dividend = 8'd60;
    dif.divisor  = 8'd7;
    dif.start    = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    snap = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("no_done_after_reset", done_cnt - snap, 0);

    // A second start mid-operation must be ignored.
    issue(8'd200, 8'd9, SGN ? 8'hFA : 8'h16, SGN ? 8'hFE : 8'h02, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    dif.dividend = 8'd50;
    dif.divisor  = 8'd5;
    dif.start    = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;

    // start held through DONE: ignored there, accepted in the following IDLE cycle.
    issue(8'd17, 8'd3, 8'h05, 8'h02, 1'b0, 1'b0);
    n = 0;
    while (!dif.done && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chk("done_timeout", 1, 0);
    dif.dividend = 8'd99;
    dif.divisor  = 8'd10;
    dif.start    = 1'b1;
    @(negedge clk);
    push_exp(8'h09, 8'h09, 1'b0, 1'b0);
    @(negedge clk);
    dif.start = 1'b0;

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
